// File: rtl/axil_reg_if_pkg.sv
// Shared definitions for the AXI-Lite to register-strobe adapters (read and write side).
package axil_reg_if_pkg;

   localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

   // Width of the timeout down-counter; it must hold TIMEOUT-1.
   function automatic int timeout_cnt_w(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/axil_reg_if_rd_if.sv
// AXI-Lite read address / read data channels between a bus master and the register adapter.
interface axil_reg_if_rd_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output araddr, arprot, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  araddr, arprot, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axil_reg_if_rd.sv
// AXI-Lite read channel to register read strobe adapter. One request is held in a
// one-deep AR buffer; a timeout forces completion so an unmapped register never hangs the bus.
module axil_reg_if_rd
   import axil_reg_if_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   axil_reg_if_rd_if.slave       s_axil,
   output logic [ADDR_WIDTH-1:0] reg_rd_addr,
   output logic                  reg_rd_en,
   input  logic [DATA_WIDTH-1:0] reg_rd_data,
   input  logic                  reg_rd_wait,
   input  logic                  reg_rd_ack
);

   localparam int CNT_W = timeout_cnt_w(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TIMEOUT - 1);

   logic                  ar_hold;
   logic                  rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [CNT_W-1:0]      cnt_q;

   logic                  ar_hold_d;
   logic                  rvalid_d;
   logic                  reg_rd_en_d;
   logic [DATA_WIDTH-1:0] rdata_d;
   logic [CNT_W-1:0]      cnt_d;
   logic [ADDR_WIDTH-1:0] reg_rd_addr_d;

   logic                  ar_hs;
   logic                  r_hs;
   logic                  complete;

   // arprot carries no meaning here and STRB_WIDTH exists only for wrapper symmetry.
   logic unused_ok;
   assign unused_ok = (^s_axil.arprot) ^ (STRB_WIDTH == 0);

   assign s_axil.arready = !ar_hold;
   assign s_axil.rvalid  = rvalid_q;
   assign s_axil.rdata   = rdata_q;
   assign s_axil.rresp   = AXIL_RESP_OKAY;

   assign ar_hs    = s_axil.arvalid && !ar_hold;
   assign r_hs     = rvalid_q && s_axil.rready;
   // An ack in the same cycle the counter expires still wins and returns its data.
   assign complete = reg_rd_en && (reg_rd_ack || (cnt_q == '0));

   // Next-state: AR buffer, R beat, request strobe, timeout counter and captured data.
   always_comb begin
      ar_hold_d     = ar_hold;
      rvalid_d      = rvalid_q;
      rdata_d       = rdata_q;
      cnt_d         = cnt_q;
      reg_rd_addr_d = reg_rd_addr;

      // AR handshake and completion are mutually exclusive: completion needs ar_hold=1,
      // which also keeps arready low.
      if (ar_hs) begin
         ar_hold_d     = 1'b1;
         reg_rd_addr_d = s_axil.araddr;
      end else if (complete) begin
         ar_hold_d = 1'b0;
      end

      // Completion needs reg_rd_en, which is never high while an R beat is pending.
      if (complete) begin
         rvalid_d = 1'b1;
         rdata_d  = reg_rd_ack ? reg_rd_data : '0;
      end else if (r_hs) begin
         rvalid_d = 1'b0;
      end

      if (!ar_hold) begin
         cnt_d = CNT_RELOAD;
      end else if (reg_rd_en && !reg_rd_wait && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end

      // A buffered request waits until the previous R beat has been accepted.
      reg_rd_en_d = ar_hold_d && !rvalid_d;
   end

   // Register update; the captured address is plain data and carries no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ar_hold   <= 1'b0;
         rvalid_q  <= 1'b0;
         reg_rd_en <= 1'b0;
         rdata_q   <= '0;
         cnt_q     <= CNT_RELOAD;
      end else begin
         ar_hold   <= ar_hold_d;
         rvalid_q  <= rvalid_d;
         reg_rd_en <= reg_rd_en_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
      end
      reg_rd_addr <= reg_rd_addr_d;
   end

endmodule

// File: tb/tb_axil_reg_if_rd.sv
// Directed bench for the AXI-Lite read adapter. Inputs change and outputs are sampled
// 1 ns after each rising edge; "cycle Tn" is the interval following the n-th edge.
module tb_axil_reg_if_rd;

   logic        clk;
   logic        rst;
   logic [31:0] reg_rd_addr;
   logic        reg_rd_en;
   logic [31:0] reg_rd_data;
   logic        reg_rd_wait;
   logic        reg_rd_ack;

   int checks;
   int failures;

   axil_reg_if_rd_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s_axil ();

   axil_reg_if_rd #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .STRB_WIDTH(4),
      .TIMEOUT   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_axil     (s_axil),
      .reg_rd_addr(reg_rd_addr),
      .reg_rd_en  (reg_rd_en),
      .reg_rd_data(reg_rd_data),
      .reg_rd_wait(reg_rd_wait),
      .reg_rd_ack (reg_rd_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++; if (s_axil.arready !== 1'b1) begin failures++; $display("FAIL reset_arready got=%b exp=1", s_axil.arready); end
      checks++; if (s_axil.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", s_axil.rvalid); end
      checks++; if (reg_rd_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", reg_rd_en); end
      checks++; if (s_axil.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", s_axil.rdata); end
      // ack and rready while idle must be ignored
      reg_rd_ack = 1'b1; reg_rd_data = 32'hFFFF_FFFF; s_axil.rready = 1'b1;
      tick();
      checks++; if (s_axil.rvalid !== 1'b0) begin failures++; $display("FAIL idle_ack_rvalid got=%b exp=0", s_axil.rvalid); end
      checks++; if (s_axil.rdata !== 32'h0) begin failures++; $display("FAIL idle_ack_rdata got=%h exp=00000000", s_axil.rdata); end
      reg_rd_ack = 1'b0; s_axil.rready = 1'b0;
   endtask

   task automatic test_basic_read();
      s_axil.araddr = 32'h10; s_axil.arvalid = 1'b1;
      tick();
      s_axil.arvalid = 1'b0;
      checks++; if (reg_rd_en !== 1'b1) begin failures++; $display("FAIL basic_en_t1 got=%b exp=1", reg_rd_en); end
      checks++; if (reg_rd_addr !== 32'h10) begin failures++; $display("FAIL basic_addr got=%h exp=00000010", reg_rd_addr); end
      checks++; if (s_axil.arready !== 1'b0) begin failures++; $display("FAIL basic_arready_t1 got=%b exp=0", s_axil.arready); end
      reg_rd_ack = 1'b1; reg_rd_data = 32'hDEAD_BEEF;
      tick();
      reg_rd_ack = 1'b0;
      checks++; if (s_axil.rvalid !== 1'b1) begin failures++; $display("FAIL basic_rvalid got=%b exp=1", s_axil.rvalid); end
      checks++; if (s_axil.rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_rdata got=%h exp=deadbeef", s_axil.rdata); end
      checks++; if (s_axil.rresp !== 2'b00) begin failures++; $display("FAIL basic_rresp got=%b exp=00", s_axil.rresp); end
      checks++; if (reg_rd_en !== 1'b0) begin failures++; $display("FAIL basic_en_t2 got=%b exp=0", reg_rd_en); end
      checks++; if (s_axil.arready !== 1'b1) begin failures++; $display("FAIL basic_arready_t2 got=%b exp=1", s_axil.arready); end
      s_axil.rready = 1'b1;
      tick();
      s_axil.rready = 1'b0;
      checks++; if (s_axil.rvalid !== 1'b0) begin failures++; $display("FAIL basic_rvalid_clr got=%b exp=0", s_axil.rvalid); end
   endtask

   task automatic test_timeout();
      s_axil.araddr = 32'h44; s_axil.arvalid = 1'b1;
      tick();
      s_axil.arvalid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (reg_rd_en !== 1'b1 || s_axil.rvalid !== 1'b0) begin failures++; $display("FAIL timeout_T%0d en=%b rvalid=%b exp en=1 rvalid=0", i, reg_rd_en, s_axil.rvalid); end
         if (i < 4) tick();
      end
      reg_rd_data = 32'h1111_2222;
      tick();
      checks++; if (s_axil.rvalid !== 1'b1 || reg_rd_en !== 1'b0) begin failures++; $display("FAIL timeout_T5 rvalid=%b en=%b exp rvalid=1 en=0", s_axil.rvalid, reg_rd_en); end
      checks++; if (s_axil.rdata !== 32'h0) begin failures++; $display("FAIL timeout_rdata got=%h exp=00000000", s_axil.rdata); end
      s_axil.rready = 1'b1;
      tick();
      s_axil.rready = 1'b0;
   endtask

   task automatic test_ack_at_timeout();
      s_axil.araddr = 32'h48; s_axil.arvalid = 1'b1;
      tick();
      s_axil.arvalid = 1'b0;
      tick(); tick(); tick();
      // T4: counter has reached zero; an ack here must still return its data
      checks++; if (reg_rd_en !== 1'b1) begin failures++; $display("FAIL acktmo_en_T4 got=%b exp=1", reg_rd_en); end
      reg_rd_ack = 1'b1; reg_rd_data = 32'h0000_CAFE;
      tick();
      reg_rd_ack = 1'b0;
      checks++; if (s_axil.rvalid !== 1'b1 || s_axil.rdata !== 32'h0000_CAFE) begin failures++; $display("FAIL acktmo_rdata rvalid=%b got=%h exp rvalid=1 0000cafe", s_axil.rvalid, s_axil.rdata); end
      s_axil.rready = 1'b1;
      tick();
      s_axil.rready = 1'b0;
   endtask

   task automatic test_wait_stretch();
      s_axil.araddr = 32'h30; s_axil.arvalid = 1'b1;
      tick();
      s_axil.arvalid = 1'b0;
      reg_rd_wait = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (reg_rd_en !== 1'b1 || s_axil.rvalid !== 1'b0) begin failures++; $display("FAIL wait_cycle%0d en=%b rvalid=%b exp en=1 rvalid=0", i, reg_rd_en, s_axil.rvalid); end
      end
      reg_rd_wait = 1'b0;
      reg_rd_ack = 1'b1; reg_rd_data = 32'h5;
      tick();
      reg_rd_ack = 1'b0;
      checks++; if (s_axil.rvalid !== 1'b1 || s_axil.rdata !== 32'h5) begin failures++; $display("FAIL wait_rdata rvalid=%b got=%h exp rvalid=1 00000005", s_axil.rvalid, s_axil.rdata); end
      s_axil.rready = 1'b1;
      tick();
      s_axil.rready = 1'b0;
   endtask

   task automatic test_back_to_back();
      s_axil.araddr = 32'h50; s_axil.arvalid = 1'b1;
      tick();
      s_axil.arvalid = 1'b0;
      reg_rd_ack = 1'b1; reg_rd_data = 32'hA5A5_A5A5;
      tick();
      reg_rd_ack = 1'b0;
      // T2: first beat pending, second AR presented
      checks++; if (s_axil.rvalid !== 1'b1 || s_axil.arready !== 1'b1) begin failures++; $display("FAIL b2b_T2 rvalid=%b arready=%b exp 1 1", s_axil.rvalid, s_axil.arready); end
      s_axil.araddr = 32'h20; s_axil.arvalid = 1'b1;
      tick();
      s_axil.arvalid = 1'b0;
      checks++; if (s_axil.arready !== 1'b0) begin failures++; $display("FAIL b2b_ar_accepted arready=%b exp=0", s_axil.arready); end
      for (int i = 3; i <= 7; i++) begin
         checks++; if (s_axil.rvalid !== 1'b1 || s_axil.rdata !== 32'hA5A5_A5A5 || reg_rd_en !== 1'b0) begin failures++; $display("FAIL b2b_hold_T%0d rvalid=%b rdata=%h en=%b exp 1 a5a5a5a5 0", i, s_axil.rvalid, s_axil.rdata, reg_rd_en); end
         if (i == 7) s_axil.rready = 1'b1;
         tick();
      end
      s_axil.rready = 1'b0;
      // T8: beat accepted, buffered request now issued
      checks++; if (s_axil.rvalid !== 1'b0 || reg_rd_en !== 1'b1) begin failures++; $display("FAIL b2b_T8 rvalid=%b en=%b exp 0 1", s_axil.rvalid, reg_rd_en); end
      checks++; if (reg_rd_addr !== 32'h20) begin failures++; $display("FAIL b2b_addr got=%h exp=00000020", reg_rd_addr); end
      reg_rd_ack = 1'b1; reg_rd_data = 32'h77;
      tick();
      reg_rd_ack = 1'b0;
      checks++; if (s_axil.rvalid !== 1'b1 || s_axil.rdata !== 32'h77) begin failures++; $display("FAIL b2b_second_rdata rvalid=%b got=%h exp 1 00000077", s_axil.rvalid, s_axil.rdata); end
      s_axil.rready = 1'b1;
      tick();
      s_axil.rready = 1'b0;
   endtask

   task automatic test_mid_op_reset();
      s_axil.araddr = 32'h60; s_axil.arvalid = 1'b1;
      tick();
      s_axil.arvalid = 1'b0;
      checks++; if (reg_rd_en !== 1'b1) begin failures++; $display("FAIL midrst_en got=%b exp=1", reg_rd_en); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (reg_rd_en !== 1'b0 || s_axil.arready !== 1'b1) begin failures++; $display("FAIL midrst_after en=%b arready=%b exp 0 1", reg_rd_en, s_axil.arready); end
      tick(); tick();
      checks++; if (s_axil.rvalid !== 1'b0) begin failures++; $display("FAIL midrst_no_rvalid got=%b exp=0", s_axil.rvalid); end
      s_axil.araddr = 32'h8; s_axil.arvalid = 1'b1;
      tick();
      s_axil.arvalid = 1'b0;
      checks++; if (reg_rd_en !== 1'b1 || reg_rd_addr !== 32'h8) begin failures++; $display("FAIL midrst_next_req en=%b addr=%h exp 1 00000008", reg_rd_en, reg_rd_addr); end
      reg_rd_ack = 1'b1; reg_rd_data = 32'h1234;
      tick();
      reg_rd_ack = 1'b0;
      checks++; if (s_axil.rvalid !== 1'b1 || s_axil.rdata !== 32'h1234) begin failures++; $display("FAIL midrst_next_rdata rvalid=%b got=%h exp 1 00001234", s_axil.rvalid, s_axil.rdata); end
      s_axil.rready = 1'b1;
      tick();
      s_axil.rready = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      s_axil.araddr = '0;
      s_axil.arprot = 3'b000;
      s_axil.arvalid = 1'b0;
      s_axil.rready = 1'b0;
      reg_rd_data = '0;
      reg_rd_wait = 1'b0;
      reg_rd_ack = 1'b0;
      test_reset();
      test_basic_read();
      test_timeout();
      test_ack_at_timeout();
      test_wait_stretch();
      test_back_to_back();
      test_mid_op_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
